// File: rtl/cache_arbiter.sv
// ============================================================================
// Module   : cache_arbiter
// Brief    : Serialises I-cache and D-cache line misses onto one memory port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_arbiter #(
  parameter int LINE_W   = 256,
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEM_I = 2'd1,
    MEM_D = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   r_last_grant;   // 0 = I side, 1 = D side
  logic   r_d_is_write;
  logic   w_d_req;
  logic   w_grant_i;
  logic   w_grant_d;
  logic   unused_offset_bits;

  assign w_d_req = d_read | d_write;
  assign unused_offset_bits = ^{i_addr[OFFSET_W-1:0], d_addr[OFFSET_W-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      IDLE: begin
        // On contention the side that did not win last time goes first
        if (i_read && w_d_req) begin
          w_grant_i = r_last_grant;
          w_grant_d = ~r_last_grant;
        end else begin
          w_grant_i = i_read;
          w_grant_d = w_d_req;
        end
        if (w_grant_i) begin
          w_state_next = MEM_I;
        end else if (w_grant_d) begin
          w_state_next = MEM_D;
        end
      end
      MEM_I, MEM_D: begin
        if (mem_resp) begin
          w_state_next = RESP;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b0;
      r_d_is_write <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_resp       <= 1'b0;
      d_resp       <= 1'b0;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      if (w_grant_i) begin
        r_last_grant <= 1'b0;
        mem_addr     <= {i_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
      end
      if (w_grant_d) begin
        r_last_grant <= 1'b1;
        r_d_is_write <= d_write;
        mem_addr     <= {d_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        mem_wdata    <= d_wdata;
      end
      if (r_state == MEM_I && mem_resp) begin
        i_rdata <= mem_rdata;
        i_resp  <= 1'b1;
      end
      // A write-back completion leaves the D-side line register untouched
      if (r_state == MEM_D && mem_resp) begin
        d_resp <= 1'b1;
        if (!r_d_is_write) begin
          d_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_read  = (r_state == MEM_I) || ((r_state == MEM_D) && !r_d_is_write);
  assign mem_write = (r_state == MEM_D) && r_d_is_write;

endmodule

`default_nettype wire
